key_sweep_miter: RTL and testbench
==================================

# key_sweep_miter

Sequential, parametrised successor to the single-shot equivalence miter: instead of comparing one original/encrypted output pair for one externally supplied key, it drives the input pattern and the key candidate itself and compares the two circuit outputs cycle by cycle. It sweeps every key over all 2^N_IN input patterns and aborts a key at its first mismatch. It reports the first passing key and a count of passing keys. It sits in the verification top, beside the `orgcir`/`enccir` instances, whose outputs it samples.

## Interface
Parameters:
- N_IN, 5, primary inputs of the circuit under lock; the pattern counter width.
- N_OUT, 2, compared outputs.
- KEY_W, 2, locking key width; the key counter width.
- STOP_ON_PASS, 1, 1 = finish at the first passing key; 0 = sweep every key.

Ports. One clock; reset is synchronous and active-high.
- C, in, 1, clock; all state updates on the rising edge.
- R, in, 1, synchronous active-high reset.
- start, in, 1, begin a sweep; sampled only in IDLE or DONE.
- pat, out, N_IN, registered input pattern to both circuits.
- key, out, KEY_W, registered key candidate to `enccir`.
- org_out, in, N_OUT, original circuit outputs (combinational from pat).
- enc_out, in, N_OUT, encrypted circuit outputs (combinational from pat and key).
- Q, out, N_OUT, registered per-bit match of the last evaluation.
- Z, out, 1, registered AND of Q.
- busy, out, 1, high in SWEEP.
- done, out, 1, one-cycle pulse on entry to DONE.
- found, out, 1, at least one key passed all patterns.
- good_key, out, KEY_W, first passing key; valid while found=1.
- pass_cnt, out, KEY_W+1, number of passing keys.

## Operation
- States: IDLE, SWEEP, DONE.
- Reset forces state IDLE and every output register to 0: pat, key, Q, Z, busy, done, found, good_key, pass_cnt.
- Reset overrides everything, including a sweep in progress. No partial result survives it.
- IDLE/DONE + start=1: go to SWEEP, pat=0, key=0, found=0, good_key=0, pass_cnt=0, busy=1.
- Results hold in DONE until the next accepted start.
- start is ignored while busy=1.
- SWEEP evaluates one (key, pat) pair per cycle: m = (org_out == enc_out) bitwise. Q is loaded with m and Z with &m.
  - Mismatch (any bit of m is 0): the key fails; key advances by 1 and pat returns to 0.
  - Match and pat != all-ones: pat advances by 1.
  - Match and pat == all-ones: the key passes. pass_cnt increments. If found=0, set found=1 and good_key=key. Then if STOP_ON_PASS=1, go to DONE; otherwise key advances by 1 and pat returns to 0.
- Termination: when the current key is all-ones and it finishes (by failing or by passing), go to DONE; key does not wrap.
- done=1 for exactly the first DONE cycle. busy=0 in IDLE and in DONE.
- Arithmetic: pat and key are unsigned and increment modulo 2^width, but the FSM never wraps them. pass_cnt saturates at 2^KEY_W, which is also its maximum reachable value.

## Timing
- Accepting start on edge E0 drives pat=0 and key=0 in cycle 1. The first evaluation is sampled on E1.
- Each evaluation samples the combinational response to the registered pat/key of the current cycle. There is one pattern per cycle and no bubbles.
- Q and Z lag the evaluated pair by one cycle.
- A failing key costs (index of its first mismatching pattern + 1) cycles. A passing key costs 2^N_IN cycles.
- DONE is entered on the edge of the final evaluation, so done is high in the cycle after it.

## Structure
- Package `key_sweep_pkg`:
  - state enum {IDLE, SWEEP, DONE};
  - a localparam for the pass_cnt width (KEY_W+1);
  - a function returning the all-ones value of a given width.
- Sub-module `miter_cmp` (combinational, parametrised by N_OUT): takes org_out and enc_out, returns m and its AND-reduction. It is reused by later miter tops.
- The FSM, the counters and the result registers live in `key_sweep_miter`.

## Test plan
Defaults, wired to the 5-input NAND benchmark whose correct key is 2'b01 (k0 feeds an XNOR, k1 feeds an XOR):
- Reset mid-sweep (assert R while busy=1): the next cycle has state IDLE and pat=key=Q=Z=pass_cnt=0, with found=0 and busy=0.
- start, STOP_ON_PASS=1:
  - key 00 fails on pattern 0 (1 cycle); key 01 passes after 32 cycles.
  - done pulses 33 cycles after the start edge, with found=1, good_key=01 and pass_cnt=1.
- STOP_ON_PASS=0:
  - keys 10 and 11 each fail on pattern 0.
  - done pulses 35 cycles after start, with good_key=01, pass_cnt=1 and a final key of 11.
- start held high for the whole sweep: it is ignored while busy, and a single sweep results. Re-asserting start in DONE clears found and pass_cnt and reruns with identical results.
- Identity wiring (enc_out tied to org_out), KEY_W=2, STOP_ON_PASS=0: every key passes; pass_cnt=4, good_key=00, and done arrives 128 cycles after start.
- Force a mismatch only on pattern 31 for every key: each key takes 32 cycles. found=0 and pass_cnt=0, Q shows the failing bit on the cycle after each mismatch, and Z=0 there.

Source files
------------

// File: rtl/key_sweep_pkg.sv
// Shared types and helpers for the key-sweep miter family.
// No logic; sizes and the sweep state enum live here.
package key_sweep_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } sweep_state_t;

   // pass_cnt is one bit wider than the key so it can hold 2^KEY_W
   localparam int PASS_CNT_XTRA = 1;

   localparam int ONES_MAX_W = 32;

   function automatic logic [ONES_MAX_W-1:0] all_ones(input int w);
      logic [ONES_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < ONES_MAX_W; i++) begin
         if (i < w) r[i] = 1'b1;
      end
      return r;
   endfunction

endpackage

// File: rtl/key_sweep_miter_cmp.sv
// Bitwise output comparator for miters: per-bit match plus its AND.
// Purely combinational, zero latency, no flow control.
module miter_cmp #(
   parameter int N_OUT = 2
) (
   input  logic [N_OUT-1:0] org_out,
   input  logic [N_OUT-1:0] enc_out,
   output logic [N_OUT-1:0] m,
   output logic             m_all
);

   assign m     = ~(org_out ^ enc_out);
   assign m_all = &m;

endmodule

// File: rtl/key_sweep_miter.sv
// Sweeps every key over all input patterns, aborting a key on first mismatch; reports first passing key and pass count.
// One (key, pat) evaluation per cycle, Q/Z one cycle behind; start is ignored while busy.
module key_sweep_miter
   import key_sweep_pkg::*;
#(
   parameter int N_IN         = 5,
   parameter int N_OUT        = 2,
   parameter int KEY_W        = 2,
   parameter int STOP_ON_PASS = 1
) (
   input  logic                            C,
   input  logic                            R,
   input  logic                            start,
   output logic [N_IN-1:0]                 pat,
   output logic [KEY_W-1:0]                key,
   input  logic [N_OUT-1:0]                org_out,
   input  logic [N_OUT-1:0]                enc_out,
   output logic [N_OUT-1:0]                Q,
   output logic                            Z,
   output logic                            busy,
   output logic                            done,
   output logic                            found,
   output logic [KEY_W-1:0]                good_key,
   output logic [KEY_W+PASS_CNT_XTRA-1:0]  pass_cnt
);

   localparam int                PC_W     = KEY_W + PASS_CNT_XTRA;
   localparam logic [N_IN-1:0]   PAT_LAST = N_IN'(all_ones(N_IN));
   localparam logic [KEY_W-1:0]  KEY_LAST = KEY_W'(all_ones(KEY_W));
   localparam logic [PC_W-1:0]   PC_SAT   = PC_W'(all_ones(KEY_W)) + PC_W'(1);

   sweep_state_t      state_q, state_d;
   logic [N_IN-1:0]   pat_q, pat_d;
   logic [KEY_W-1:0]  key_q, key_d;
   logic [N_OUT-1:0]  q_q, q_d;
   logic              z_q, z_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              found_q, found_d;
   logic [KEY_W-1:0]  good_key_q, good_key_d;
   logic [PC_W-1:0]   pass_cnt_q, pass_cnt_d;

   logic [N_OUT-1:0]  m;
   logic              m_all;
   logic              key_end;

   miter_cmp #(.N_OUT(N_OUT)) u_cmp (
      .org_out (org_out),
      .enc_out (enc_out),
      .m       (m),
      .m_all   (m_all)
   );

   always_comb begin
      state_d    = state_q;
      pat_d      = pat_q;
      key_d      = key_q;
      q_d        = q_q;
      z_d        = z_q;
      busy_d     = busy_q;
      done_d     = 1'b0;
      found_d    = found_q;
      good_key_d = good_key_q;
      pass_cnt_d = pass_cnt_q;
      key_end    = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d    = SWEEP;
               pat_d      = '0;
               key_d      = '0;
               found_d    = 1'b0;
               good_key_d = '0;
               pass_cnt_d = '0;
               busy_d     = 1'b1;
            end
         end
         SWEEP: begin
            q_d = m;
            z_d = m_all;
            if (!m_all) begin
               key_end = 1'b1;
            end else if (pat_q != PAT_LAST) begin
               pat_d = pat_q + N_IN'(1);
            end else begin
               key_end = 1'b1;
               if (pass_cnt_q != PC_SAT) pass_cnt_d = pass_cnt_q + PC_W'(1);
               if (!found_q) begin
                  found_d    = 1'b1;
                  good_key_d = key_q;
               end
            end
            // The last key never advances, so the key counter cannot wrap
            if (key_end) begin
               if (key_q == KEY_LAST || (m_all && STOP_ON_PASS != 0)) begin
                  state_d = DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end else begin
                  key_d = key_q + KEY_W'(1);
                  pat_d = '0;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge C) begin
      if (R) begin
         state_q    <= IDLE;
         pat_q      <= '0;
         key_q      <= '0;
         q_q        <= '0;
         z_q        <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         found_q    <= 1'b0;
         good_key_q <= '0;
         pass_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         pat_q      <= pat_d;
         key_q      <= key_d;
         q_q        <= q_d;
         z_q        <= z_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         found_q    <= found_d;
         good_key_q <= good_key_d;
         pass_cnt_q <= pass_cnt_d;
      end
   end

   assign pat      = pat_q;
   assign key      = key_q;
   assign Q        = q_q;
   assign Z        = z_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign found    = found_q;
   assign good_key = good_key_q;
   assign pass_cnt = pass_cnt_q;

endmodule

// File: tb/tb_key_sweep_miter.sv
// Bench for key_sweep_miter: one instance sweeping all keys, one stopping at the first pass,
// both driven by a locked 5-input NAND/parity circuit or by a table of planted per-key faults.
module tb_key_sweep_miter;

   localparam int N_IN  = 5;
   localparam int N_OUT = 2;
   localparam int KEY_W = 2;
   localparam int NK    = 4;
   localparam int NP    = 32;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic              start_i  [2];
   logic [N_IN-1:0]   pat_o    [2];
   logic [KEY_W-1:0]  key_o    [2];
   logic [N_OUT-1:0]  org_o    [2];
   logic [N_OUT-1:0]  enc_o    [2];
   logic [N_OUT-1:0]  q_o      [2];
   logic              z_o      [2];
   logic              busy_o   [2];
   logic              done_o   [2];
   logic              found_o  [2];
   logic [KEY_W-1:0]  good_o   [2];
   logic [KEY_W:0]    cnt_o    [2];

   // mode 0: locked benchmark; mode 1: enc = org except mask flipped at pattern fidx[key]
   int               mode;
   int               fidx  [NK];
   logic [N_OUT-1:0] fmask [NK];

   int n_chk  = 0;
   int n_pass = 0;

   function automatic logic [N_OUT-1:0] org_f(input logic [N_IN-1:0] p);
      return {^p, ~&p};
   endfunction

   function automatic logic [N_OUT-1:0] enc_f(input int md, input int fi, input logic [N_OUT-1:0] fm,
                                              input logic [KEY_W-1:0] k, input logic [N_IN-1:0] p);
      logic [N_OUT-1:0] o;
      o = org_f(p);
      if (md == 0) return {o[1] ^ k[1], ~(o[0] ^ k[0])};
      return (int'(p) == fi) ? (o ^ fm) : o;
   endfunction

   function automatic logic [N_OUT-1:0] m_f(input int k, input int p);
      logic [KEY_W-1:0] kk;
      logic [N_IN-1:0]  pp;
      kk = k[KEY_W-1:0];
      pp = p[N_IN-1:0];
      return ~(org_f(pp) ^ enc_f(mode, fidx[kk], fmask[kk], kk, pp));
   endfunction

   assign org_o[0] = org_f(pat_o[0]);
   assign org_o[1] = org_f(pat_o[1]);
   assign enc_o[0] = enc_f(mode, fidx[key_o[0]], fmask[key_o[0]], key_o[0], pat_o[0]);
   assign enc_o[1] = enc_f(mode, fidx[key_o[1]], fmask[key_o[1]], key_o[1], pat_o[1]);

   key_sweep_miter #(.N_IN(N_IN), .N_OUT(N_OUT), .KEY_W(KEY_W), .STOP_ON_PASS(0)) u_sweep_all (
      .C(clk), .R(rst), .start(start_i[0]), .pat(pat_o[0]), .key(key_o[0]),
      .org_out(org_o[0]), .enc_out(enc_o[0]), .Q(q_o[0]), .Z(z_o[0]), .busy(busy_o[0]),
      .done(done_o[0]), .found(found_o[0]), .good_key(good_o[0]), .pass_cnt(cnt_o[0])
   );

   key_sweep_miter #(.N_IN(N_IN), .N_OUT(N_OUT), .KEY_W(KEY_W), .STOP_ON_PASS(1)) u_stop_first (
      .C(clk), .R(rst), .start(start_i[1]), .pat(pat_o[1]), .key(key_o[1]),
      .org_out(org_o[1]), .enc_out(enc_o[1]), .Q(q_o[1]), .Z(z_o[1]), .busy(busy_o[1]),
      .done(done_o[1]), .found(found_o[1]), .good_key(good_o[1]), .pass_cnt(cnt_o[1])
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
   endtask

   // Reference: per DUT, the list of (key, pat) pairs evaluated in order and the
   // found/good/count values after each evaluation.
   int exp_p [2][$];
   int exp_k [2][$];
   int exp_f [2][$];
   int exp_g [2][$];
   int exp_c [2][$];
   int exp_key   [2];
   int seen_done [2];

   task automatic build_model();
      for (int d = 0; d < 2; d++) begin
         int fnd, gk, cnt;
         bit stop_now;
         fnd = 0; gk = 0; cnt = 0; stop_now = 0;
         exp_p[d].delete(); exp_k[d].delete(); exp_f[d].delete();
         exp_g[d].delete(); exp_c[d].delete();
         for (int k = 0; k < NK && !stop_now; k++) begin
            for (int p = 0; p < NP; p++) begin
               logic [N_OUT-1:0] m;
               m = m_f(k, p);
               if (m == 2'b11 && p == NP - 1) begin
                  cnt++;
                  if (fnd == 0) begin fnd = 1; gk = k; end
                  if (d == 1) stop_now = 1;
               end
               exp_p[d].push_back(p); exp_k[d].push_back(k); exp_f[d].push_back(fnd);
               exp_g[d].push_back(gk); exp_c[d].push_back(cnt);
               if (m != 2'b11) break;
            end
            exp_key[d] = k;
         end
      end
   endtask

   task automatic run_sweep(input bit hold);
      int n [2];
      int last;
      build_model();
      for (int d = 0; d < 2; d++) begin
         n[d] = exp_p[d].size();
         seen_done[d] = -1;
      end
      last = ((n[0] > n[1]) ? n[0] : n[1]) + 2;
      @(negedge clk);
      start_i[0] = 1'b1; start_i[1] = 1'b1;
      @(posedge clk); #1;
      if (!hold) begin start_i[0] = 1'b0; start_i[1] = 1'b0; end
      for (int e = 0; e <= last; e++) begin
         for (int d = 0; d < 2; d++) begin
            int ix;
            logic [N_OUT-1:0] m;
            if (done_o[d] && seen_done[d] < 0) seen_done[d] = e;
            if (e < n[d]) begin
               chk($sformatf("d%0d pat e%0d", d, e), int'(pat_o[d]), exp_p[d][e]);
               chk($sformatf("d%0d key e%0d", d, e), int'(key_o[d]), exp_k[d][e]);
            end else begin
               chk($sformatf("d%0d final key e%0d", d, e), int'(key_o[d]), exp_key[d]);
            end
            if (e == 0) begin
               chk($sformatf("d%0d cnt cleared", d), int'(cnt_o[d]), 0);
               chk($sformatf("d%0d found cleared", d), int'(found_o[d]), 0);
            end else begin
               ix = (e <= n[d]) ? e - 1 : n[d] - 1;
               m  = m_f(exp_k[d][ix], exp_p[d][ix]);
               chk($sformatf("d%0d Q e%0d", d, e), int'(q_o[d]), int'(m));
               chk($sformatf("d%0d Z e%0d", d, e), int'(z_o[d]), int'(&m));
               chk($sformatf("d%0d found e%0d", d, e), int'(found_o[d]), exp_f[d][ix]);
               chk($sformatf("d%0d good e%0d", d, e), int'(good_o[d]), exp_g[d][ix]);
               chk($sformatf("d%0d cnt e%0d", d, e), int'(cnt_o[d]), exp_c[d][ix]);
            end
            chk($sformatf("d%0d busy e%0d", d, e), int'(busy_o[d]), int'(e < n[d]));
            chk($sformatf("d%0d done e%0d", d, e), int'(done_o[d]), int'(e == n[d]));
            if (hold && e == n[d]) start_i[d] = 1'b0;
         end
         @(posedge clk); #1;
      end
      start_i[0] = 1'b0; start_i[1] = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s d%0d pat", tag, d), int'(pat_o[d]), 0);
         chk($sformatf("%s d%0d key", tag, d), int'(key_o[d]), 0);
         chk($sformatf("%s d%0d Q", tag, d), int'(q_o[d]), 0);
         chk($sformatf("%s d%0d Z", tag, d), int'(z_o[d]), 0);
         chk($sformatf("%s d%0d busy", tag, d), int'(busy_o[d]), 0);
         chk($sformatf("%s d%0d done", tag, d), int'(done_o[d]), 0);
         chk($sformatf("%s d%0d found", tag, d), int'(found_o[d]), 0);
         chk($sformatf("%s d%0d good", tag, d), int'(good_o[d]), 0);
         chk($sformatf("%s d%0d cnt", tag, d), int'(cnt_o[d]), 0);
      end
   endtask

   typedef struct {
      int md;   int hold; int fi;   int fm;
      int len0; int len1; int fnd0; int fnd1;
      int gk0;  int gk1;  int cnt0; int cnt1;
      int key0; int key1;
   } vec_t;

   vec_t vt [5];

   initial begin
      vt[0] = '{0, 0,  0, 0,  35,  33, 1, 1, 1, 1, 1, 1, 3, 1};  // locked benchmark
      vt[1] = '{0, 1,  0, 0,  35,  33, 1, 1, 1, 1, 1, 1, 3, 1};  // start held through sweep
      vt[2] = '{0, 0,  0, 0,  35,  33, 1, 1, 1, 1, 1, 1, 3, 1};  // rerun from DONE
      vt[3] = '{1, 0, 32, 0, 128,  32, 1, 1, 0, 0, 4, 1, 3, 0};  // identity wiring
      vt[4] = '{1, 0, 31, 1, 128, 128, 0, 0, 0, 0, 0, 0, 3, 3};  // mismatch on last pattern only

      rst = 1'b1; start_i[0] = 1'b0; start_i[1] = 1'b0; mode = 0;
      for (int k = 0; k < NK; k++) begin fidx[k] = NP; fmask[k] = '0; end
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset");
      rst = 1'b0;

      for (int i = 0; i < 5; i++) begin
         mode = vt[i].md;
         for (int k = 0; k < NK; k++) begin
            fidx[k]  = vt[i].fi;
            fmask[k] = N_OUT'(vt[i].fm);
         end
         run_sweep(vt[i].hold != 0);
         chk($sformatf("v%0d d0 done cycle", i), seen_done[0], vt[i].len0);
         chk($sformatf("v%0d d1 done cycle", i), seen_done[1], vt[i].len1);
         chk($sformatf("v%0d d0 found", i), int'(found_o[0]), vt[i].fnd0);
         chk($sformatf("v%0d d1 found", i), int'(found_o[1]), vt[i].fnd1);
         chk($sformatf("v%0d d0 good_key", i), int'(good_o[0]), vt[i].gk0);
         chk($sformatf("v%0d d1 good_key", i), int'(good_o[1]), vt[i].gk1);
         chk($sformatf("v%0d d0 pass_cnt", i), int'(cnt_o[0]), vt[i].cnt0);
         chk($sformatf("v%0d d1 pass_cnt", i), int'(cnt_o[1]), vt[i].cnt1);
         chk($sformatf("v%0d d0 key", i), int'(key_o[0]), vt[i].key0);
         chk($sformatf("v%0d d1 key", i), int'(key_o[1]), vt[i].key1);
      end

      // Reset mid-sweep: d0 still sweeping, d1 already in DONE with a result
      mode = 1;
      for (int k = 0; k < NK; k++) begin fidx[k] = NP; fmask[k] = '0; end
      @(negedge clk);
      start_i[0] = 1'b1; start_i[1] = 1'b1;
      @(negedge clk);
      start_i[0] = 1'b0; start_i[1] = 1'b0;
      repeat (40) @(negedge clk);
      chk("pre-reset d0 busy", int'(busy_o[0]), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      chk_zero("mid-sweep reset");
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post-reset d0 stays idle", int'(busy_o[0]), 0);
      chk("post-reset d1 stays idle", int'(busy_o[1]), 0);

      // Randomised fault tables checked against the reference
      for (int r = 0; r < 6; r++) begin
         mode = 1;
         for (int k = 0; k < NK; k++) begin
            int v;
            v = int'($urandom_range(0, 47));
            fidx[k]  = (v > NP - 1) ? NP : v;
            fmask[k] = N_OUT'($urandom_range(1, 3));
         end
         run_sweep($urandom_range(0, 1) == 1);
         for (int d = 0; d < 2; d++) begin
            chk($sformatf("rnd%0d d%0d done cycle", r, d), seen_done[d], exp_p[d].size());
            chk($sformatf("rnd%0d d%0d pass_cnt", r, d), int'(cnt_o[d]), exp_c[d][exp_c[d].size() - 1]);
            chk($sformatf("rnd%0d d%0d found", r, d), int'(found_o[d]), exp_f[d][exp_f[d].size() - 1]);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
